// File: rtl/byte_scatter_4.sv
// byte_scatter_4: one-word input routed to four registered byte lanes, either narrowed into a selected lane or scattered across all four.
// Optional macro BYTE_SCATTER_SAT_EN selects signed saturation for the narrow path (default build truncates).
`timescale 1ns/1ps

module byte_scatter_4 #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [1:0]       select,
    input  logic [IN_W-1:0]  i,
    output logic [OUT_W-1:0] o0,
    output logic [OUT_W-1:0] o1,
    output logic [OUT_W-1:0] o2,
    output logic [OUT_W-1:0] o3,
    output logic [3:0]       o_valid,
    output logic             sat
);

    typedef enum logic {IDLE, SCATTER} state_t;

    state_t            state, state_next;
    logic [1:0]        cnt, cnt_next;
    logic [IN_W-1:0]   word;
    logic [OUT_W-1:0]  lane_q [4];
    logic [3:0]        wr_valid;
    logic [OUT_W-1:0]  wr_data;
    logic              sat_next;
    logic              capture;
    logic [OUT_W-1:0]  narrow_data;
    logic              narrow_sat;

    assign in_ready = (state == IDLE) && !reset;

`ifdef BYTE_SCATTER_SAT_EN
    // The word fits the lane only if every bit from the lane sign bit upward is a copy of it.
    always_comb begin
        narrow_data = i[OUT_W-1:0];
        narrow_sat  = 1'b0;
        if (!(&i[IN_W-1:OUT_W-1]) && (|i[IN_W-1:OUT_W-1])) begin
            narrow_sat  = 1'b1;
            narrow_data = i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    assign narrow_data = i[OUT_W-1:0];
    assign narrow_sat  = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_next = state;
        cnt_next   = cnt;
        wr_valid   = '0;
        wr_data    = '0;
        sat_next   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (!mode) begin
                        wr_valid[select] = 1'b1;
                        wr_data          = narrow_data;
                        sat_next         = narrow_sat;
                    end else begin
                        capture    = 1'b1;
                        cnt_next   = 2'd0;
                        state_next = SCATTER;
                    end
                end
            end
            SCATTER: begin
                wr_valid[cnt] = 1'b1;
                wr_data       = word[int'(cnt)*OUT_W +: OUT_W];
                cnt_next      = cnt + 2'd1;
                if (cnt == 2'd3) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: lanes are visible outputs and must read 0 after reset; the captured word is only read in SCATTER and needs no reset.
            for (int k = 0; k < 4; k++) lane_q[k] <= '0;
            o_valid <= '0;
            sat     <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (wr_valid[k]) lane_q[k] <= wr_data;
            end
            o_valid <= wr_valid;
            sat     <= sat_next;
        end
        if (capture) word <= i;
    end

    assign o0 = lane_q[0];
    assign o1 = lane_q[1];
    assign o2 = lane_q[2];
    assign o3 = lane_q[3];

endmodule

// File: tb/tb_byte_scatter_4.sv
// Directed self-checking bench for byte_scatter_4; expectations follow BYTE_SCATTER_SAT_EN when it is defined.
`timescale 1ns/1ps

module tb_byte_scatter_4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [1:0]  select;
    logic [31:0] i;
    logic [7:0]  o0, o1, o2, o3;
    logic [3:0]  o_valid;
    logic        sat;

    int tests = 0;
    int fails = 0;

`ifdef BYTE_SCATTER_SAT_EN
    localparam logic [7:0] POS_CLAMP = 8'h7F;
    localparam logic [7:0] NEG_CLAMP = 8'h80;
    localparam logic       SAT_FLAG  = 1'b1;
`else
    localparam logic [7:0] POS_CLAMP = 8'h00;
    localparam logic [7:0] NEG_CLAMP = 8'h00;
    localparam logic       SAT_FLAG  = 1'b0;
`endif

    byte_scatter_4 #(.IN_W(32), .OUT_W(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .select(select), .i(i),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o_valid(o_valid), .sat(sat)
    );

    always #5 clock = ~clock;

    // Advance one edge and settle 1 ns past it before sampling or driving.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] lane(input int k);
        case (k)
            0: return o0;
            1: return o1;
            2: return o2;
            default: return o3;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; mode = 1'b0; select = 2'd0; i = 32'h55;
        step(); step();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
        tests++; if ({o3, o2, o1, o0} !== 32'h0) begin fails++; $display("FAIL reset_lanes: got %h, expected 00000000", {o3, o2, o1, o0}); end
        tests++; if (o_valid !== 4'b0000) begin fails++; $display("FAIL reset_o_valid: got %b, expected 0000", o_valid); end
        tests++; if (sat !== 1'b0) begin fails++; $display("FAIL reset_sat: got %b, expected 0", sat); end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b, expected 1", in_ready); end
    endtask

    // First transfer lands in the first cycle after reset release.
    task automatic test_narrow();
        in_valid = 1'b1; mode = 1'b0; select = 2'd2; i = 32'hFFFFFF85;
        step();
        in_valid = 1'b0;
        tests++; if ({o3, o2, o1, o0} !== 32'h00850000) begin fails++; $display("FAIL narrow_lanes: got %h, expected 00850000", {o3, o2, o1, o0}); end
        tests++; if (o_valid !== 4'b0100) begin fails++; $display("FAIL narrow_o_valid: got %b, expected 0100", o_valid); end
        tests++; if (sat !== 1'b0) begin fails++; $display("FAIL narrow_sat: got %b, expected 0", sat); end
        step();
        tests++; if (o_valid !== 4'b0000) begin fails++; $display("FAIL narrow_pulse_end: got %b, expected 0000", o_valid); end
        tests++; if (o2 !== 8'h85) begin fails++; $display("FAIL narrow_hold: got %h, expected 85", o2); end
    endtask

    task automatic test_saturate();
        in_valid = 1'b1; mode = 1'b0; select = 2'd1; i = 32'h00000200;
        step();
        tests++; if (o1 !== POS_CLAMP) begin fails++; $display("FAIL sat_pos_data: got %h, expected %h", o1, POS_CLAMP); end
        tests++; if (sat !== SAT_FLAG) begin fails++; $display("FAIL sat_pos_flag: got %b, expected %b", sat, SAT_FLAG); end
        tests++; if (o_valid !== 4'b0010) begin fails++; $display("FAIL sat_pos_o_valid: got %b, expected 0010", o_valid); end
        select = 2'd0; i = 32'hFFFF0000;
        step();
        in_valid = 1'b0;
        tests++; if (o0 !== NEG_CLAMP) begin fails++; $display("FAIL sat_neg_data: got %h, expected %h", o0, NEG_CLAMP); end
        tests++; if (sat !== SAT_FLAG) begin fails++; $display("FAIL sat_neg_flag: got %b, expected %b", sat, SAT_FLAG); end
        tests++; if ({o3, o2, o1} !== {8'h00, 8'h85, POS_CLAMP}) begin fails++; $display("FAIL sat_other_lanes: got %h, expected %h", {o3, o2, o1}, {8'h00, 8'h85, POS_CLAMP}); end
        step();
        tests++; if (sat !== 1'b0) begin fails++; $display("FAIL sat_pulse_end: got %b, expected 0", sat); end
    endtask

    task automatic test_scatter();
        logic [7:0] exp_b [4];
        exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        in_valid = 1'b1; mode = 1'b1; select = 2'd3; i = 32'hDDCCBBAA;
        step();
        in_valid = 1'b0; i = 32'h0;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL scatter_accept_ready: got %b, expected 0", in_ready); end
        tests++; if (o_valid !== 4'b0000) begin fails++; $display("FAIL scatter_accept_o_valid: got %b, expected 0000", o_valid); end
        for (int k = 0; k < 4; k++) begin
            step();
            tests++; if (o_valid !== (4'b0001 << k)) begin fails++; $display("FAIL scatter_o_valid_%0d: got %b, expected %b", k, o_valid, 4'b0001 << k); end
            tests++; if (lane(k) !== exp_b[k]) begin fails++; $display("FAIL scatter_data_%0d: got %h, expected %h", k, lane(k), exp_b[k]); end
            tests++; if (sat !== 1'b0) begin fails++; $display("FAIL scatter_sat_%0d: got %b, expected 0", k, sat); end
            tests++; if (in_ready !== (k == 3)) begin fails++; $display("FAIL scatter_ready_%0d: got %b, expected %b", k, in_ready, k == 3); end
        end
        step();
        tests++; if (o_valid !== 4'b0000) begin fails++; $display("FAIL scatter_done_o_valid: got %b, expected 0000", o_valid); end
        tests++; if ({o3, o2, o1, o0} !== 32'hDDCCBBAA) begin fails++; $display("FAIL scatter_final_lanes: got %h, expected DDCCBBAA", {o3, o2, o1, o0}); end
    endtask

    // A second word held on in_valid during the scatter must wait for in_ready.
    task automatic test_stall();
        logic [7:0] exp_b [4];
        int pulses;
        exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
        pulses = 0;
        in_valid = 1'b1; mode = 1'b1; i = 32'h11223344;
        step();
        mode = 1'b0; select = 2'd3; i = 32'h0000005A;
        for (int k = 0; k < 4; k++) begin
            step();
            pulses += $countones(o_valid);
            tests++; if (o_valid !== (4'b0001 << k)) begin fails++; $display("FAIL stall_o_valid_%0d: got %b, expected %b", k, o_valid, 4'b0001 << k); end
            tests++; if (lane(k) !== exp_b[k]) begin fails++; $display("FAIL stall_data_%0d: got %h, expected %h", k, lane(k), exp_b[k]); end
        end
        step();
        in_valid = 1'b0;
        pulses += $countones(o_valid);
        tests++; if (o3 !== 8'h5A) begin fails++; $display("FAIL stall_second_data: got %h, expected 5A", o3); end
        tests++; if (o_valid !== 4'b1000) begin fails++; $display("FAIL stall_second_o_valid: got %b, expected 1000", o_valid); end
        step();
        pulses += $countones(o_valid);
        tests++; if (pulses !== 5) begin fails++; $display("FAIL stall_write_count: got %0d, expected 5", pulses); end
    endtask

    task automatic test_reset_abort();
        in_valid = 1'b1; mode = 1'b1; i = 32'hA1B2C3D4;
        step();
        in_valid = 1'b0;
        step(); step();
        tests++; if ({o1, o0} !== 16'hC3D4) begin fails++; $display("FAIL abort_pre_lanes: got %h, expected C3D4", {o1, o0}); end
        reset = 1'b1;
        step();
        tests++; if ({o3, o2, o1, o0} !== 32'h0) begin fails++; $display("FAIL abort_reset_lanes: got %h, expected 00000000", {o3, o2, o1, o0}); end
        tests++; if (o_valid !== 4'b0000) begin fails++; $display("FAIL abort_reset_o_valid: got %b, expected 0000", o_valid); end
        reset = 1'b0;
        step();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL abort_in_ready: got %b, expected 1", in_ready); end
        for (int k = 0; k < 3; k++) begin
            tests++; if ({o3, o2, o1, o0, o_valid} !== 36'h0) begin fails++; $display("FAIL abort_no_resume_%0d: got %h, expected 000000000", k, {o3, o2, o1, o0, o_valid}); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] sel_v [4];
        logic [7:0] dat_v [4];
        sel_v = '{2'd3, 2'd0, 2'd3, 2'd1};
        dat_v = '{8'h12, 8'h34, 8'h56, 8'h78};
        in_valid = 1'b1; mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            select = sel_v[k]; i = {24'h0, dat_v[k]};
            step();
            tests++; if (o_valid !== (4'b0001 << sel_v[k])) begin fails++; $display("FAIL b2b_o_valid_%0d: got %b, expected %b", k, o_valid, 4'b0001 << sel_v[k]); end
            tests++; if (lane(int'(sel_v[k])) !== dat_v[k]) begin fails++; $display("FAIL b2b_data_%0d: got %h, expected %h", k, lane(int'(sel_v[k])), dat_v[k]); end
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_%0d: got %b, expected 1", k, in_ready); end
        end
        in_valid = 1'b0;
        step();
        tests++; if (o_valid !== 4'b0000) begin fails++; $display("FAIL b2b_end_o_valid: got %b, expected 0000", o_valid); end
        tests++; if ({o3, o2, o1, o0} !== 32'h56007834) begin fails++; $display("FAIL b2b_final_lanes: got %h, expected 56007834", {o3, o2, o1, o0}); end
    endtask

    initial begin
        test_reset();
        test_narrow();
        test_saturate();
        test_scatter();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/byte_scatter_4.md
BYTE_SCATTER_4 -- requirements
Module: byte_scatter_4

Interface
REQ-001 Parameter IN_W, default 32, width of the input word; SHALL equal 4*OUT_W.
REQ-002 Parameter OUT_W, default 8, width of each lane output.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  input word offered.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 mode  input  1  0 = narrow one word into the selected lane, 1 = scatter all four bytes across lanes.
REQ-008 select  input  2  target lane for mode 0; ignored in mode 1.
REQ-009 i  input  IN_W  signed input word.
REQ-010 o0, o1, o2, o3  output  OUT_W each  registered lane outputs.
REQ-011 o_valid  output  4  bit k pulses high for one cycle when lane k is written.
REQ-012 sat  output  1  pulses high with o_valid when a narrow write saturated.

Function
REQ-013 Transfer SHALL occur at a rising edge where in_valid=1 and in_ready=1; mode, select and i are sampled at that edge.
REQ-014 FSM states SHALL be IDLE and SCATTER; in_ready=1 in IDLE, 0 in SCATTER and while reset=1.
REQ-015 Mode-0 transfer: the block SHALL stay in IDLE, write narrow(i) to lane select at the next edge, and set o_valid[select]=1 for exactly one cycle; latency 1.
REQ-016 Back-to-back mode-0 transfers SHALL be accepted every cycle; each write is produced one cycle after its transfer.
REQ-017 Mode-1 transfer: the block SHALL capture i, enter SCATTER with a 2-bit lane counter at 0, and on the next 4 edges write byte k (i[8k+7:8k]) to lane k in order 0,1,2,3, asserting o_valid[k] alone on each.
REQ-018 After the lane-3 write the FSM SHALL return to IDLE, and in_ready SHALL be 1 in the following cycle; accept-to-accept spacing is 5 cycles.
REQ-019 in_valid while in_ready=0 SHALL be ignored; the stalled word is not captured.
REQ-020 Scatter writes SHALL never assert sat; lane counter wrap from 3 SHALL coincide with the exit to IDLE.
REQ-021 Lanes not written in a cycle SHALL hold their values; o_valid bits not written SHALL be 0.
REQ-022 At most one o_valid bit SHALL be high in any cycle.

Reset
REQ-023 reset=1 at an edge SHALL force o0..o3=0, o_valid=0, sat=0, state IDLE, and lane counter 0.
REQ-024 Reset during SCATTER SHALL abort it; unwritten lanes are not written afterwards.
REQ-025 The first transfer SHALL be possible in the first cycle after reset deasserts.

Configuration
REQ-026 Macro BYTE_SCATTER_SAT_EN defined: narrow(i) SHALL saturate signed i to [-128,127], giving 8'h7F if i>127 and 8'h80 if i<-128, with sat pulsed alongside o_valid when clamping occurs.
REQ-027 Macro BYTE_SCATTER_SAT_EN undefined: narrow(i) SHALL be i[7:0] (truncation) and sat SHALL be constant 0.

Verification
REQ-028 Mode 0, select=2, i=32'hFFFFFF85 -> next cycle o2=8'h85, o_valid=4'b0100, sat=0; other lanes unchanged.
REQ-029 Mode 0, select=1, i=32'h00000200 -> SAT_EN: o1=8'h7F, sat=1; without: o1=8'h00, sat=0.
REQ-030 Mode 1, i=32'hDDCCBBAA -> o0=AA, o1=BB, o2=CC, o3=DD on 4 consecutive cycles, o_valid 0001,0010,0100,1000; in_ready low 4 cycles.
REQ-031 in_valid held high during scatter with a second word -> second word accepted only after in_ready returns to 1; no extra writes.
REQ-032 reset asserted after the lane-1 scatter write -> all lanes 0, o_valid 0, in_ready 1 one cycle after reset deasserts.
REQ-033 Four back-to-back mode-0 transfers to lanes 3,0,3,1 -> four consecutive single-bit o_valid pulses with the matching data.
